// File: rtl/clock_key_ctrl.sv
// -----------------------------------------------------------------------------
// clock_key_ctrl
//   Front-panel controller for the clock counter's adjust interface. It
//   synchronises and debounces three raw active-low push-buttons, walks a mode
//   FSM RUN -> HOUR -> MIN -> SEC -> RUN on each MODE press, and emits
//   single-cycle UP/DWN pulses with auto-repeat while one adjust key is held.
//
// Ports
//   CLK       in   1  system clock (same clock as the clock counter)
//   RESET     in   1  asynchronous reset, active low
//   KEY_MODE  in   1  raw mode button, active low, asynchronous
//   KEY_UP    in   1  raw up button, active low, asynchronous
//   KEY_DWN   in   1  raw down button, active low, asynchronous
//   FLAG      out  2  adjust select: 00 run, 01 hour, 10 minute, 11 second
//   UP        out  1  one-cycle increment pulse
//   DWN       out  1  one-cycle decrement pulse
// -----------------------------------------------------------------------------
module clock_key_ctrl #(
  parameter int DEB_CYC = 2,
  parameter int REP_DLY = 50,
  parameter int REP_PER = 10,
  parameter int MODE_TO = 1000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       KEY_MODE,
  input  logic       KEY_UP,
  input  logic       KEY_DWN,
  output logic [1:0] FLAG,
  output logic       UP,
  output logic       DWN
);

  localparam int DEB_W  = $clog2(DEB_CYC + 1);
  localparam int REP_W  = $clog2(REP_DLY + 1);
  localparam int IDLE_W = (MODE_TO > 0) ? $clog2(MODE_TO + 1) : 1;

  // Counters compare against the value one below the target so the action
  // lands on the edge where the count would reach the parameter.
  localparam logic [DEB_W-1:0]  DEB_LAST   = DEB_W'(DEB_CYC - 1);
  localparam logic [REP_W-1:0]  REP_LAST   = REP_W'(REP_DLY - 1);
  // After a repeat pulse the counter restarts part-way so the next pulse
  // follows REP_PER cycles later instead of REP_DLY.
  localparam logic [REP_W-1:0]  REP_RELOAD = REP_W'(REP_DLY - REP_PER);
  localparam logic [IDLE_W-1:0] IDLE_MAX   = IDLE_W'(MODE_TO);
  localparam bit                TO_EN      = (MODE_TO > 0);

  localparam int K_MODE = 0;
  localparam int K_UP   = 1;
  localparam int K_DWN  = 2;

  typedef enum logic [1:0] {
    S_RUN  = 2'b00,
    S_HOUR = 2'b01,
    S_MIN  = 2'b10,
    S_SEC  = 2'b11
  } state_t;

  logic [2:0]        w_raw;
  logic [2:0]        r_sync1;
  logic [2:0]        r_sync2;
  logic [2:0]        r_stable;
  logic [2:0]        r_evt;
  logic [DEB_W-1:0]  r_deb [3];

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_adj;
  logic              w_chg;
  logic              w_timeout;
  logic [1:0]        w_held;      // bit 0 = up, bit 1 = down

  logic              r_up;
  logic              r_dwn;
  logic [REP_W-1:0]  r_rep;
  logic [1:0]        r_arm;
  logic [IDLE_W-1:0] r_idle;
  logic              w_up_nxt;
  logic              w_dwn_nxt;
  logic [REP_W-1:0]  w_rep_nxt;
  logic [1:0]        w_arm_nxt;
  logic [IDLE_W-1:0] w_idle_nxt;

  assign w_raw = {KEY_DWN, KEY_UP, KEY_MODE};

  // ---- stage: synchroniser and debounce ------------------------------------
  // A press event is registered on the same edge that the stable level falls,
  // so it is visible for exactly the following cycle.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_sync1  <= '1;
      r_sync2  <= '1;
      r_stable <= '1;
      r_evt    <= '0;
      for (int k = 0; k < 3; k++) r_deb[k] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int k = 0; k < 3; k++) begin
        r_evt[k] <= 1'b0;
        if (r_sync2[k] != r_stable[k]) begin
          if (r_deb[k] == DEB_LAST) begin
            r_stable[k] <= r_sync2[k];
            r_deb[k]    <= '0;
            r_evt[k]    <= ~r_sync2[k];
          end else begin
            r_deb[k] <= r_deb[k] + 1'b1;
          end
        end else begin
          r_deb[k] <= '0;
        end
      end
    end
  end

  // ---- stage: mode FSM -----------------------------------------------------
  assign w_adj     = (r_state != S_RUN);
  assign w_timeout = TO_EN && w_adj && (r_idle == IDLE_MAX);
  assign w_chg     = (w_state_nxt != r_state);
  assign w_held    = ~r_stable[K_DWN:K_UP];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_state <= S_RUN;
    else        r_state <= w_state_nxt;
  end

  // Timeout takes priority over a MODE press landing on the same edge.
  always_comb begin
    w_state_nxt = r_state;
    if (w_timeout)           w_state_nxt = S_RUN;
    else if (r_evt[K_MODE])  w_state_nxt = state_t'(r_state + 2'd1);
  end

  // ---- stage: pulse, repeat and idle next-state ----------------------------
  // A key only auto-repeats after its own press event in the current adjust
  // state (r_arm), so a key held across a state change stays silent.
  always_comb begin
    w_up_nxt   = 1'b0;
    w_dwn_nxt  = 1'b0;
    w_rep_nxt  = '0;
    w_arm_nxt  = '0;
    w_idle_nxt = '0;
    if (w_adj && !w_chg) begin
      w_arm_nxt = r_arm | r_evt[K_DWN:K_UP];
      if (&w_held) begin
        w_rep_nxt = '0;
      end else if (r_evt[K_UP]) begin
        w_up_nxt = 1'b1;
      end else if (r_evt[K_DWN]) begin
        w_dwn_nxt = 1'b1;
      end else if (|(w_held & r_arm)) begin
        if (r_rep == REP_LAST) begin
          w_up_nxt  = w_held[0];
          w_dwn_nxt = w_held[1];
          w_rep_nxt = REP_RELOAD;
        end else begin
          w_rep_nxt = r_rep + 1'b1;
        end
      end
      if (!(|r_evt) && (&r_stable) && (r_idle != IDLE_MAX))
        w_idle_nxt = r_idle + 1'b1;
      else if (!(|r_evt) && (&r_stable))
        w_idle_nxt = r_idle;
    end
  end

  // ---- stage: output registers ---------------------------------------------
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_up   <= 1'b0;
      r_dwn  <= 1'b0;
      r_rep  <= '0;
      r_arm  <= '0;
      r_idle <= '0;
    end else begin
      r_up   <= w_up_nxt;
      r_dwn  <= w_dwn_nxt;
      r_rep  <= w_rep_nxt;
      r_arm  <= w_arm_nxt;
      r_idle <= w_idle_nxt;
    end
  end

  assign FLAG = r_state;
  assign UP   = r_up;
  assign DWN  = r_dwn;

endmodule
